// File: rtl/ant_field_if.sv
// Pixel-stream bundle between the VGA timing generator, the Langton's-ant
// world store and the downstream DAC. The master side drives timing and
// pixel coordinates; the slave side returns delayed syncs, the colour and
// the running step count.
interface ant_field_if;
    logic        run;
    logic        hsync_in;
    logic        vsync_in;
    logic        pix_en;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic [15:0] step_count;

    modport master (
        output run, hsync_in, vsync_in, pix_en, xpos, ypos,
        input  hsync, vsync, rgb, step_count
    );

    modport slave (
        input  run, hsync_in, vsync_in, pix_en, xpos, ypos,
        output hsync, vsync, rgb, step_count
    );
endinterface

// File: rtl/ant_field.sv
// Langton's-ant world: 1-bit-per-cell grid in a single-port RAM, a step
// FSM that advances the ant during vertical blanking, and a 2-stage render
// pipeline that turns the timing generator's pixel position into a colour.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | write 0 to every cell, one address per cycle
// S_IDLE  | wait for a vsync falling edge with run=1
// S_READ  | drive the ant's cell address onto the RAM port
// S_TURN  | read data valid; rotate right on white, left on black
// S_WRITE | write the inverted cell value back
// S_MOVE  | step one cell in the new direction (toroidal), count the step
module ant_field #(
    parameter int GRID_W          = 100,
    parameter int GRID_H          = 75,
    parameter int CELL_SHIFT      = 3,
    parameter int STEPS_PER_FRAME = 1
) (
    input  logic       clk,
    input  logic       rst,
    ant_field_if.slave io_bus
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int XW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int YW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_TURN,
        S_WRITE,
        S_MOVE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_clr_addr;
    logic [XW-1:0] r_ax;
    logic [YW-1:0] r_ay;
    logic [1:0]    r_dir;
    logic [10:0]   r_remaining;
    logic [15:0]   r_step_count;
    logic          r_cell;

    logic          r_mem [CELLS];
    logic          r_rd_data;

    logic          r_hs_d1;
    logic          r_hs_d2;
    logic          r_vs_d1;
    logic          r_vs_d2;
    logic          r_pe_d1;
    logic          r_is_ant;
    logic [2:0]    r_rgb;

    logic [9:0]    w_rcx;
    logic [9:0]    w_rcy;
    logic [AW-1:0] w_render_addr;
    logic [AW-1:0] w_ant_addr;
    logic [AW-1:0] w_mem_addr;
    logic          w_mem_we;
    logic          w_mem_wdata;
    logic          w_vs_fall;

    assign w_rcx         = io_bus.xpos >> CELL_SHIFT;
    assign w_rcy         = io_bus.ypos >> CELL_SHIFT;
    assign w_render_addr = AW'(w_rcy) * AW'(GRID_W) + AW'(w_rcx);
    assign w_ant_addr    = AW'(r_ay) * AW'(GRID_W) + AW'(r_ax);
    // r_vs_d1 doubles as the previous-cycle vsync for edge detection.
    assign w_vs_fall     = r_vs_d1 & ~io_bus.vsync_in;

    // RAM port arbitration: clear and step accesses take the port, render gets it otherwise.
    always_comb begin
        w_mem_addr  = w_render_addr;
        w_mem_we    = 1'b0;
        w_mem_wdata = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_mem_addr  = r_clr_addr;
                w_mem_we    = 1'b1;
                w_mem_wdata = 1'b0;
            end
            S_READ: begin
                w_mem_addr = w_ant_addr;
            end
            S_WRITE: begin
                w_mem_addr  = w_ant_addr;
                w_mem_we    = 1'b1;
                w_mem_wdata = ~r_cell;
            end
            default: begin
            end
        endcase
    end

    // Grid RAM: single port, read-first, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        r_rd_data <= r_mem[w_mem_addr];
    end

    // Clear and ant-step controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CLEAR;
            r_clr_addr   <= '0;
            r_ax         <= XW'(GRID_W / 2);
            r_ay         <= YW'(GRID_H / 2);
            r_dir        <= 2'd0;
            r_remaining  <= '0;
            r_step_count <= '0;
            r_cell       <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_addr == AW'(CELLS - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_clr_addr <= r_clr_addr + AW'(1);
                    end
                end
                S_IDLE: begin
                    if (w_vs_fall && io_bus.run) begin
                        r_remaining <= 11'(STEPS_PER_FRAME);
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_TURN;
                end
                S_TURN: begin
                    r_cell  <= r_rd_data;
                    r_dir   <= r_rd_data ? (r_dir - 2'd1) : (r_dir + 2'd1);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_state <= S_MOVE;
                end
                S_MOVE: begin
                    case (r_dir)
                        2'd0: r_ay <= (r_ay == '0) ? YW'(GRID_H - 1) : (r_ay - YW'(1));
                        2'd1: r_ax <= (r_ax == XW'(GRID_W - 1)) ? '0 : (r_ax + XW'(1));
                        2'd2: r_ay <= (r_ay == YW'(GRID_H - 1)) ? '0 : (r_ay + YW'(1));
                        default: r_ax <= (r_ax == '0) ? XW'(GRID_W - 1) : (r_ax - XW'(1));
                    endcase
                    r_step_count <= r_step_count + 16'd1;
                    r_remaining  <= r_remaining - 11'd1;
                    r_state      <= (r_remaining == 11'd1) ? S_IDLE : S_READ;
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

    // Render pipeline and sync delay line; both paths are two registers deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_d1  <= 1'b1;
            r_hs_d2  <= 1'b1;
            r_vs_d1  <= 1'b1;
            r_vs_d2  <= 1'b1;
            r_pe_d1  <= 1'b0;
            r_is_ant <= 1'b0;
            r_rgb    <= 3'b000;
        end else begin
            r_hs_d1  <= io_bus.hsync_in;
            r_hs_d2  <= r_hs_d1;
            r_vs_d1  <= io_bus.vsync_in;
            r_vs_d2  <= r_vs_d1;
            r_pe_d1  <= io_bus.pix_en;
            r_is_ant <= (w_rcx == 10'(r_ax)) && (w_rcy == 10'(r_ay));
            if (!r_pe_d1 || (r_state == S_CLEAR)) begin
                r_rgb <= 3'b000;
            end else if (r_is_ant) begin
                r_rgb <= 3'b100;
            end else if (r_rd_data) begin
                r_rgb <= 3'b000;
            end else begin
                r_rgb <= 3'b111;
            end
        end
    end

    assign io_bus.hsync      = r_hs_d2;
    assign io_bus.vsync      = r_vs_d2;
    assign io_bus.rgb        = r_rgb;
    assign io_bus.step_count = r_step_count;

endmodule

// File: tb/tb_ant_field.sv
// Bench for ant_field: four instances (full-size world, 4x4 turn world,
// 2x2 wrap world, 4x4 world with 8-step bursts). Stimulus pushes the
// expected {hsync, vsync, rgb, step_count} two cycles ahead into a
// scoreboard; a negedge monitor pops and compares.
module tb_ant_field;
    localparam int N_DUT = 4;
    localparam int GW  [N_DUT] = '{100, 4, 2, 4};
    localparam int GH  [N_DUT] = '{75, 4, 2, 4};
    localparam int SPF [N_DUT] = '{1, 1, 1, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [N_DUT];
    logic        run_v [N_DUT];
    logic        hs_v  [N_DUT];
    logic        vs_v  [N_DUT];
    logic        pe_v  [N_DUT];
    logic [9:0]  x_v   [N_DUT];
    logic [9:0]  y_v   [N_DUT];
    logic        hs_o  [N_DUT];
    logic        vs_o  [N_DUT];
    logic [2:0]  rgb_o [N_DUT];
    logic [15:0] sc_o  [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        ant_field_if ifc ();
        assign ifc.run      = run_v[g];
        assign ifc.hsync_in = hs_v[g];
        assign ifc.vsync_in = vs_v[g];
        assign ifc.pix_en   = pe_v[g];
        assign ifc.xpos     = x_v[g];
        assign ifc.ypos     = y_v[g];
        assign hs_o[g]      = ifc.hsync;
        assign vs_o[g]      = ifc.vsync;
        assign rgb_o[g]     = ifc.rgb;
        assign sc_o[g]      = ifc.step_count;

        ant_field #(
            .GRID_W         (GW[g]),
            .GRID_H         (GH[g]),
            .CELL_SHIFT     (3),
            .STEPS_PER_FRAME(SPF[g])
        ) dut (
            .clk   (clk),
            .rst   (rst_v[g]),
            .io_bus(ifc.slave)
        );
    end

    typedef struct {
        int          due;
        int          id;
        logic [20:0] exp;
        string       tag;
    } sb_t;

    sb_t  sb_q [$];
    sb_t  mon_e;
    logic [20:0] mon_act;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   exp_sc [N_DUT];
    bit   mgrid [16];

    int   b_x [6] = '{3, 3, 2, 2, 1, 1};
    int   b_y [6] = '{2, 3, 3, 2, 2, 1};
    int   c_x [4] = '{0, 0, 1, 1};
    int   c_y [4] = '{1, 0, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every scoreboard entry whose due cycle has come.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e   = sb_q.pop_front();
            mon_act = {hs_o[mon_e.id], vs_o[mon_e.id], rgb_o[mon_e.id], sc_o[mon_e.id]};
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_errors++;
                $display("FAIL %s dut%0d cyc %0d: got hs=%b vs=%b rgb=%b sc=%0d, want hs=%b vs=%b rgb=%b sc=%0d",
                         mon_e.tag, mon_e.id, cyc,
                         mon_act[20], mon_act[19], mon_act[18:16], mon_act[15:0],
                         mon_e.exp[20], mon_e.exp[19], mon_e.exp[18:16], mon_e.exp[15:0]);
            end
        end
    end

    task automatic apply(input int g, input int x, input int y,
                         input logic pe, input logic hs, input logic vs);
        @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            pe_v[i] = 1'b0;
            x_v[i]  = '0;
            y_v[i]  = '0;
            hs_v[i] = 1'b1;
            vs_v[i] = 1'b1;
        end
        pe_v[g] = pe;
        x_v[g]  = 10'(x);
        y_v[g]  = 10'(y);
        hs_v[g] = hs;
        vs_v[g] = vs;
    endtask

    task automatic pix(input int g, input int x, input int y, input logic pe,
                       input logic hs, input logic vs, input logic [2:0] rgb,
                       input string tag);
        sb_t e;
        apply(g, x, y, pe, hs, vs);
        e.due = cyc + 2;
        e.id  = g;
        e.exp = {hs, vs, rgb, 16'(exp_sc[g])};
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) apply(0, 0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic frame(input int g, input logic r);
        apply(g, 0, 0, 1'b0, 1'b1, 1'b0);
        run_v[g] = r;
        idle(4 * SPF[g] + 8);
        if (r) exp_sc[g] += SPF[g];
    endtask

    task automatic scan_small(input int g, input int ax, input int ay, input string tag);
        logic [2:0] exp;
        for (int cy = 0; cy < GH[g]; cy++) begin
            for (int cx = 0; cx < GW[g]; cx++) begin
                if (cx == ax && cy == ay) exp = 3'b100;
                else if (mgrid[cy * GW[g] + cx]) exp = 3'b000;
                else exp = 3'b111;
                pix(g, cx * 8 + 3, cy * 8 + 6, 1'b1, 1'((cx + cy) % 2), 1'b1, exp, tag);
            end
        end
    endtask

    initial begin
        int px;
        int py;
        sb_t e;

        for (int i = 0; i < N_DUT; i++) begin
            rst_v[i]  = 1'b1;
            run_v[i]  = 1'b0;
            pe_v[i]   = 1'b0;
            x_v[i]    = '0;
            y_v[i]    = '0;
            hs_v[i]   = 1'b1;
            vs_v[i]   = 1'b1;
            exp_sc[i] = 0;
            e.due = 1;
            e.id  = i;
            e.exp = {1'b1, 1'b1, 3'b000, 16'd0};
            e.tag = "reset_state";
            sb_q.push_back(e);
        end
        for (int i = 0; i < 16; i++) mgrid[i] = 1'b0;

        @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) rst_v[i] = 1'b0;

        // Full-size world is clearing: colour must be forced black.
        pix(0, 0, 0, 1'b1, 1'b1, 1'b1, 3'b000, "clear_rgb");
        pix(0, 0, 0, 1'b0, 1'b0, 1'b1, 3'b000, "hs_delay");
        run_v[0] = 1'b1;
        pix(0, 0, 0, 1'b0, 1'b1, 1'b0, 3'b000, "vs_delay_clear_fall");
        idle(20);

        // 4x4 turn sequence from (2,2), plus a sixth step to expose dir=3.
        px = 2;
        py = 2;
        scan_small(1, px, py, "turn_init");
        for (int i = 0; i < 6; i++) begin
            frame(1, 1'b1);
            mgrid[py * 4 + px] ^= 1'b1;
            px = b_x[i];
            py = b_y[i];
            scan_small(1, px, py, "turn_step");
        end

        // 2x2 wrap world from (1,1).
        for (int i = 0; i < 16; i++) mgrid[i] = 1'b0;
        px = 1;
        py = 1;
        for (int i = 0; i < 4; i++) begin
            frame(2, 1'b1);
            mgrid[py * 2 + px] ^= 1'b1;
            px = c_x[i];
            py = c_y[i];
            scan_small(2, px, py, "wrap_step");
        end

        // 8-step burst interrupted by reset during the third TURN.
        for (int i = 0; i < 16; i++) mgrid[i] = 1'b0;
        run_v[3] = 1'b1;
        apply(3, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(7);
        exp_sc[3] = 2;
        pix(3, 0, 0, 1'b0, 1'b1, 1'b1, 3'b000, "burst_sc");
        idle(1);
        apply(3, 0, 0, 1'b0, 1'b1, 1'b1);
        rst_v[3] = 1'b1;
        exp_sc[3] = 0;
        apply(3, 0, 0, 1'b0, 1'b1, 1'b1);
        rst_v[3] = 1'b0;
        pix(3, 0, 0, 1'b1, 1'b1, 1'b1, 3'b000, "reset_clear_rgb");
        idle(24);
        scan_small(3, 2, 2, "reset_regrid");

        pix(0, 8, 8, 1'b1, 1'b1, 1'b1, 3'b000, "clear_rgb_mid");
        while (cyc < 7510) idle(1);

        // Full-size world after clear: all white, ant red at (50,37).
        for (int cy = 0; cy < 75; cy++) begin
            for (int cx = 0; cx < 100; cx++) begin
                pix(0, cx * 8, cy * 8, 1'b1, 1'b1, 1'b1,
                    (cx == 50 && cy == 37) ? 3'b100 : 3'b111, "clear_white");
            end
        end

        frame(0, 1'b1);
        for (int yy = 296; yy <= 303; yy++) begin
            for (int xx = 400; xx <= 415; xx++) begin
                pix(0, xx, yy, 1'b1, 1'b1, 1'b1, (xx < 408) ? 3'b000 : 3'b100, "first_step_px");
            end
        end
        pix(0, 0, 0, 1'b1, 1'b1, 1'b1, 3'b111, "origin_white");

        pix(0, 0, 0, 1'b0, 1'b1, 1'b1, 3'b000, "pipe_pre");
        pix(0, 0, 0, 1'b1, 1'b0, 1'b1, 3'b111, "pipe_rise");
        pix(0, 0, 0, 1'b1, 1'b1, 1'b1, 3'b111, "pipe_hold");
        pix(0, 0, 0, 1'b0, 1'b0, 1'b1, 3'b000, "pipe_fall");

        for (int i = 0; i < 3; i++) frame(0, 1'b0);
        pix(0, 408, 300, 1'b1, 1'b1, 1'b1, 3'b100, "pause_ant");
        pix(0, 400, 300, 1'b1, 1'b1, 1'b1, 3'b000, "pause_cell");

        frame(0, 1'b1);
        pix(0, 408, 300, 1'b1, 1'b1, 1'b1, 3'b000, "step2_old");
        pix(0, 408, 304, 1'b1, 1'b1, 1'b1, 3'b100, "step2_ant");
        pix(0, 400, 300, 1'b1, 1'b1, 1'b1, 3'b000, "step2_first");

        idle(4);
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
